pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the PC write enable and the enable/flush controls of the IF/ID and ID/EX pipeline registers. It resolves load-use hazards, taken-branch flushes, instruction-memory wait states and a debug halt/single-step mode. It also keeps saturating stall and flush statistics.

Parameters:
CNT_W, 16, width of stall_cycles and flush_count statistics counters
WAIT_W, 8, width of the consecutive imem-wait counter
IMEM_TIMEOUT, 64, consecutive not-ready cycles that set imem_timeout (1..2^WAIT_W-1)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
id_rs  input  5  rs field of instruction in IF/ID
id_rt  input  5  rt field of instruction in IF/ID
id_uses_rt  input  1  ID instruction reads rt as a source
ex_mem_read  input  1  instruction in EX is a load
ex_rt  input  5  destination (rt) of the load in EX
branch_taken  input  1  branch/jump resolved taken in EX this cycle
imem_ready  input  1  instruction memory returns valid data this cycle
halt_req  input  1  debug halt request (level)
resume  input  1  debug resume pulse
step  input  1  debug single-step pulse
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads NOP (32'b0)
id_ex_flush  output  1  ID/EX loads a bubble
halted  output  1  state == HALTED
imem_timeout  output  1  sticky imem wait timeout flag
stall_cycles  output  CNT_W  cycles lost to load-use or imem wait
flush_count  output  CNT_W  number of taken-branch flush cycles

Behaviour:
- Registered FSM: RUN=0, IMEM_WAIT=1, HALTED=2, STEP=3. Control outputs are combinational from state and inputs, so they act in the same cycle.
- Reset (reset=0), asynchronous:
  - state=RUN; counters and imem_timeout = 0; wait counter = 0.
  - Forced outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1.
- Definitions:
  - lu = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
  - "Normal cycle" priority, highest first:
    - branch_taken: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1; flush_count+1.
    - else lu: pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1; stall_cycles+1.
    - else !imem_ready: pc_write=0, if_id_write=1, if_id_flush=1, id_ex_flush=0; stall_cycles+1.
    - else: pc_write=1, if_id_write=1, both flushes 0.
- RUN:
  - Performs a normal cycle.
  - Next state: HALTED if halt_req; else IMEM_WAIT if !imem_ready and no branch/lu won; else RUN.
  - halt_req does not alter the current cycle's outputs.
- IMEM_WAIT:
  - Performs a normal cycle.
  - Wait counter increments while imem_ready=0 (saturating). It clears on leaving the state or on branch_taken.
  - Wait counter == IMEM_TIMEOUT sets imem_timeout; it stays set until reset.
  - Exit to RUN when imem_ready=1 or branch_taken (HALTED instead if halt_req).
- HALTED:
  - pc_write=0, if_id_write=0, if_id_flush=0, id_ex_flush=1, so downstream drains with bubbles.
  - branch_taken while HALTED is still honoured (pc_write=1, if_id_flush=1, flush_count+1); state stays HALTED.
  - resume → RUN (resume wins over step). step → STEP.
  - Stall statistics do not count halted cycles.
- STEP:
  - Performs a normal cycle; stats are counted as in RUN.
  - If that cycle advanced (pc_write=1 due to imem_ready, or a branch flush) → HALTED. Otherwise (lu or imem not ready) remain STEP.
- Counters saturate at 2^CNT_W-1. No wrap.
- Reset asserted mid-wait or mid-step returns to RUN immediately, with counters cleared.

Test Plan:
- Reset held 3 cycles then released, no hazards, imem_ready=1 → during reset pc_write=0, if_id_flush=1, id_ex_flush=1. After release: pc_write=1, if_id_write=1, flushes 0, counters 0, halted=0.
- Load-use:
  - ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle → same cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cycles=1.
  - Repeat with ex_rt=0 → no stall.
  - id_rt=5, id_uses_rt=0 → no stall.
- branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_count=1, stall_cycles unchanged.
- IMEM_TIMEOUT=4, imem_ready=0 for 6 cycles:
  - State goes to IMEM_WAIT; pc_write=0 and if_id_flush=1 each cycle.
  - imem_timeout rises when wait count hits 4 and stays 1 after imem_ready=1; stall_cycles=6.
  - State returns to RUN.
- Debug sequence:
  - halt_req=1 → next cycle halted=1, pc_write=0, id_ex_flush=1.
  - step pulse → one cycle with pc_write=1, then halted=1 again.
  - branch_taken while halted → pc_write=1, if_id_flush=1, halted stays 1.
  - resume → RUN.
- Reset asserted while in STEP with imem_ready=0 → state RUN, all counters and imem_timeout 0 immediately (asynchronously).

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the 5-stage MIPS pipeline. Resolves load-use
//   hazards, taken-branch flushes, instruction-memory wait states and a debug
//   halt/single-step mode, and keeps saturating stall/flush statistics.
//
// Ports
//   clk            pipeline clock, rising edge
//   reset          asynchronous active-low reset (0 = in reset)
//   id_rs, id_rt   source register fields of the instruction in IF/ID
//   id_uses_rt     ID instruction reads rt as a source
//   ex_mem_read    instruction in EX is a load
//   ex_rt          destination register of the load in EX
//   branch_taken   branch/jump resolved taken in EX this cycle
//   imem_ready     instruction memory returns valid data this cycle
//   halt_req       debug halt request (level)
//   resume, step   debug resume / single-step pulses
//   pc_write       PC load enable
//   if_id_write    IF/ID load enable
//   if_id_flush    IF/ID loads a NOP
//   id_ex_flush    ID/EX loads a bubble
//   halted         sequencer is in the debug-halted state
//   imem_timeout   sticky flag: imem wait exceeded IMEM_TIMEOUT cycles
//   stall_cycles   saturating count of load-use / imem-wait stall cycles
//   flush_count    saturating count of taken-branch flush cycles
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WAIT_W       = 8,
    parameter int unsigned IMEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             step,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             imem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        IMEM_WAIT = 2'd1,
        HALTED    = 2'd2,
        STEP      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic lu;
    logic advanced;
    logic stall_inc;
    logic flush_inc;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A normal cycle moves the PC forward when a branch redirects it or when
    // fetch delivered data and no load-use hazard holds it back.
    assign advanced = branch_taken || (!lu && imem_ready);

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        state_d     = state_q;
        wait_d      = '0;

        if (state_q == HALTED) begin
            // Drain downstream with bubbles; a taken branch still redirects.
            if (branch_taken) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b1;
            end
        end else begin
            if (branch_taken) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (lu) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                if_id_flush = 1'b0;
                id_ex_flush = 1'b1;
                stall_inc   = 1'b1;
            end else if (!imem_ready) begin
                pc_write    = 1'b0;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b0;
                stall_inc   = 1'b1;
            end
        end

        case (state_q)
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (!branch_taken && !lu && !imem_ready) begin
                    state_d = IMEM_WAIT;
                end
            end
            IMEM_WAIT: begin
                if (imem_ready || branch_taken) begin
                    state_d = halt_req ? HALTED : RUN;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    wait_d = wait_q;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_d = RUN;
                end else if (step) begin
                    state_d = STEP;
                end
            end
            STEP: begin
                if (advanced) begin
                    state_d = HALTED;
                end
            end
            default: state_d = RUN;
        endcase

        timeout_d = timeout_q || (wait_q == WAIT_W'(IMEM_TIMEOUT));
        stall_d   = (stall_inc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
        flush_d   = (flush_inc && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;

        // Reset forces a safe pipeline: nothing loads, both stages flushed.
        if (!reset) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign halted       = (state_q == HALTED);
    assign imem_timeout = timeout_q;
    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;

endmodule
